// File: rtl/gps_sched_pkg.sv
// gps_sched_pkg: shared state type and sizing helpers for the
// GPS IQ readout scheduler (state enum, word width, NBITS/WPC).
package gps_sched_pkg;

   localparam int WORD_W = 16;
   localparam int NIBW   = $clog2(WORD_W + 1);

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      SHIFT,
      WRITE
   } state_t;

   // serial bits held by one channel's integrator snapshot
   function automatic int nbits_f(input int e1b, input int integ_bits);
      return ((e1b != 0) ? 12 : 6) * integ_bits;
   endfunction

   // 16-bit words needed per channel
   function automatic int wpc_f(input int nbits);
      return (nbits + WORD_W - 1) / WORD_W;
   endfunction

   // index width, never below one bit
   function automatic int cw_f(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/gps_rr_arb.sv
// gps_rr_arb: combinational round-robin pick of the first request at
// or after ptr. Ports: req, ptr in; one-hot gnt, binary idx, any out.
module gps_rr_arb
   import gps_sched_pkg::*;
#(
   parameter int N = 12,
   localparam int IW = cw_f(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          any
);

   int            k;
   logic [IW-1:0] kk;

   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      k   = 0;
      kk  = '0;
      for (int i = 0; i < N; i++) begin
         // walk from ptr and wrap at N
         k = int'(ptr) + i;
         if (k >= N) k = k - N;
         kk = IW'(k);
         if (!any && req[kk]) begin
            any     = 1'b1;
            gnt[kk] = 1'b1;
            idx     = kk;
         end
      end
   end

endmodule

// File: rtl/gps_iq_readout_sched.sv
// gps_iq_readout_sched: round-robin serial readout of DEMOD IQ snapshots.
// Ports: clk/rst; epoch,sout in / shift out per channel; wr_* word port
// (valid/ready); sticky done/ovr with clears; srq = |done.
module gps_iq_readout_sched
   import gps_sched_pkg::*;
#(
   parameter int NCHANS     = 12,
   parameter int INTEG_BITS = 20,
   parameter int E1B        = 0,
   localparam int NBITS = nbits_f(E1B, INTEG_BITS),
   localparam int WPC   = wpc_f(NBITS),
   localparam int AW    = cw_f(NCHANS * WPC)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NCHANS-1:0] epoch,
   input  logic [NCHANS-1:0] sout,
   output logic [NCHANS-1:0] shift,
   output logic              wr_valid,
   input  logic              wr_ready,
   output logic [AW-1:0]     wr_addr,
   output logic [15:0]       wr_data,
   output logic              wr_last,
   output logic [NCHANS-1:0] done,
   input  logic [NCHANS-1:0] done_clr,
   output logic [NCHANS-1:0] ovr,
   input  logic [NCHANS-1:0] ovr_clr,
   output logic              srq
);

   localparam int IW  = cw_f(NCHANS);
   localparam int CW  = cw_f(NBITS + 1);
   localparam int WCW = cw_f(WPC);

   state_t state, state_n;

   logic [NCHANS-1:0] pending;
   logic [NCHANS-1:0] win_oh;
   logic [NCHANS-1:0] arb_gnt;
   logic [NCHANS-1:0] pend_clr;
   logic [NCHANS-1:0] done_set;
   logic [NCHANS-1:0] ovr_set;
   logic [NCHANS-1:0] active;
   logic [IW-1:0]     win;
   logic [IW-1:0]     ptr;
   logic [IW-1:0]     arb_idx;
   logic [IW-1:0]     ptr_nxt;
   logic              arb_any;

   logic [CW-1:0]     bitcnt;
   logic [WCW-1:0]    wcnt;
   logic [NIBW-1:0]   nib;
   logic [NIBW-1:0]   pad;
   logic [WORD_W-1:0] shreg;
   logic [WORD_W-1:0] shreg_nxt;

   logic sbit;
   logic last_bit;
   logic word_full;
   logic last_word;
   logic accept;

   gps_rr_arb #(
      .N (NCHANS)
   ) u_arb (
      .req (pending),
      .ptr (ptr),
      .gnt (arb_gnt),
      .idx (arb_idx),
      .any (arb_any)
   );

   assign ptr_nxt = (arb_idx == IW'(NCHANS - 1)) ? '0 : arb_idx + IW'(1);

   assign sbit      = |(sout & win_oh);
   assign shreg_nxt = {shreg[WORD_W-2:0], sbit};
   assign last_bit  = (bitcnt == CW'(NBITS - 1));
   assign word_full = (nib == NIBW'(WORD_W - 1));
   assign last_word = (bitcnt == CW'(NBITS));
   // bits still missing in the final word; shifting left by this
   // left-aligns a partial word and zero-fills the tail
   assign pad       = NIBW'(WORD_W - 1) - nib;

   assign accept = (state == WRITE) && wr_ready;

   // the granted channel counts as busy from GRANT until back in IDLE
   assign active  = (state != IDLE) ? win_oh : '0;
   assign ovr_set = epoch & (pending | active);

   assign shift    = (state == SHIFT) ? win_oh : '0;
   assign wr_valid = (state == WRITE);
   assign wr_last  = wr_valid && last_word;
   assign wr_addr  = AW'(win) * AW'(WPC) + AW'(wcnt);
   assign wr_data  = shreg;
   assign srq      = |done;

   always_comb begin
      state_n  = state;
      pend_clr = '0;
      done_set = '0;
      case (state)
         IDLE: begin
            if (arb_any) state_n = GRANT;
         end
         GRANT: begin
            pend_clr = win_oh;
            state_n  = SHIFT;
         end
         SHIFT: begin
            if (word_full || last_bit) state_n = WRITE;
         end
         WRITE: begin
            if (accept) begin
               if (last_word) begin
                  done_set = win_oh;
                  state_n  = IDLE;
               end else begin
                  state_n = SHIFT;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending <= '0;
         done    <= '0;
         ovr     <= '0;
      end else begin
         // new epochs win over a same-cycle grant clear
         pending <= (pending & ~pend_clr) | epoch;
         done    <= (done & ~done_clr) | done_set;
         ovr     <= (ovr & ~ovr_clr) | ovr_set;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         win    <= '0;
         win_oh <= '0;
         ptr    <= '0;
      end else if (state == IDLE && arb_any) begin
         win    <= arb_idx;
         win_oh <= arb_gnt;
         ptr    <= ptr_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bitcnt <= '0;
         wcnt   <= '0;
         nib    <= '0;
         shreg  <= '0;
      end else begin
         case (state)
            GRANT: begin
               bitcnt <= '0;
               wcnt   <= '0;
               nib    <= '0;
            end
            SHIFT: begin
               bitcnt <= bitcnt + CW'(1);
               nib    <= nib + NIBW'(1);
               if (word_full || last_bit) begin
                  shreg <= shreg_nxt << pad;
               end else begin
                  shreg <= shreg_nxt;
               end
            end
            WRITE: begin
               if (accept && !last_word) begin
                  wcnt <= wcnt + WCW'(1);
                  nib  <= '0;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
